// File: rtl/cache_mem_arbiter_if.sv
// Signal bundle between the i-/d-cache controllers, the memory arbiter and backing memory.
// The arbiter takes the slave view; the cache/memory environment takes the master view.
interface cache_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_addr_in;
    logic [DATA_WIDTH-1:0] d_addr_in;
    logic [DATA_WIDTH-1:0] i_data_in;
    logic [DATA_WIDTH-1:0] d_data_in;
    logic                  i_rw_in;
    logic                  d_rw_in;
    logic [3:0]            i_id_in;
    logic [3:0]            d_id_in;
    logic                  i_valid_in;
    logic                  d_valid_in;
    logic                  i_stall_out;
    logic                  d_stall_out;
    logic [DATA_WIDTH-1:0] i_data_out;
    logic [DATA_WIDTH-1:0] d_data_out;
    logic [3:0]            i_id_out;
    logic [3:0]            d_id_out;
    logic                  i_ready_out;
    logic                  d_ready_out;
    logic [DATA_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_rw_out;
    logic [4:0]            mem_tag_out;
    logic                  mem_valid_out;
    logic                  mem_stall_in;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [4:0]            mem_tag_in;
    logic                  mem_ready_in;
    logic                  protocol_err;

    modport slave (
        input  i_addr_in, d_addr_in, i_data_in, d_data_in, i_rw_in, d_rw_in,
               i_id_in, d_id_in, i_valid_in, d_valid_in,
               mem_stall_in, mem_data_in, mem_tag_in, mem_ready_in,
        output i_stall_out, d_stall_out, i_data_out, d_data_out, i_id_out, d_id_out,
               i_ready_out, d_ready_out, mem_addr_out, mem_data_out, mem_rw_out,
               mem_tag_out, mem_valid_out, protocol_err
    );

    modport master (
        output i_addr_in, d_addr_in, i_data_in, d_data_in, i_rw_in, d_rw_in,
               i_id_in, d_id_in, i_valid_in, d_valid_in,
               mem_stall_in, mem_data_in, mem_tag_in, mem_ready_in,
        input  i_stall_out, d_stall_out, i_data_out, d_data_out, i_id_out, d_id_out,
               i_ready_out, d_ready_out, mem_addr_out, mem_data_out, mem_rw_out,
               mem_tag_out, mem_valid_out, protocol_err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory request port between the i-cache and
// d-cache controllers, with per-source outstanding caps and tag-routed responses.
module cache_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUT    = 4
) (
    input logic               clk,
    input logic               reset,
    cache_mem_arbiter_if.slave bus
);
    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

    src_e                  last_grant_q, last_grant_d;
    logic [2:0]            cnt_i_q, cnt_i_d, cnt_d_q, cnt_d_d;
    logic [2:0]            cnt_i_dec_s, cnt_d_dec_s;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
    logic                  mem_rw_q, mem_rw_d, mem_valid_q, mem_valid_d;
    logic [4:0]            mem_tag_q, mem_tag_d;

    logic [DATA_WIDTH-1:0] i_data_q, i_data_d, d_data_q, d_data_d;
    logic [3:0]            i_id_q, i_id_d, d_id_q, d_id_d;
    logic                  i_ready_q, i_ready_d, d_ready_q, d_ready_d;

    logic                  stage_free_s, resp_i_s, resp_d_s;
    logic                  elig_i_s, elig_d_s, grant_i_s, grant_d_s;

    // Arbitration, counter bookkeeping, output-stage load and response routing.
    always_comb begin
        stage_free_s = ~mem_valid_q | ~bus.mem_stall_in;
        resp_i_s     = bus.mem_ready_in & ~bus.mem_tag_in[4];
        resp_d_s     = bus.mem_ready_in &  bus.mem_tag_in[4];

        // Eligibility looks at the post-decrement count so a capped side frees up immediately.
        if (resp_i_s && (cnt_i_q != 3'd0)) begin
            cnt_i_dec_s = cnt_i_q - 3'd1;
        end else begin
            cnt_i_dec_s = cnt_i_q;
        end
        if (resp_d_s && (cnt_d_q != 3'd0)) begin
            cnt_d_dec_s = cnt_d_q - 3'd1;
        end else begin
            cnt_d_dec_s = cnt_d_q;
        end

        elig_i_s  = bus.i_valid_in & (cnt_i_dec_s < MAX_OUT_C);
        elig_d_s  = bus.d_valid_in & (cnt_d_dec_s < MAX_OUT_C);
        grant_i_s = stage_free_s & elig_i_s & (~elig_d_s | (last_grant_q == SRC_D));
        grant_d_s = stage_free_s & elig_d_s & (~elig_i_s | (last_grant_q == SRC_I));

        cnt_i_d = cnt_i_dec_s + {2'b00, grant_i_s};
        cnt_d_d = cnt_d_dec_s + {2'b00, grant_d_s};
        err_d   = err_q | (resp_i_s & (cnt_i_q == 3'd0)) | (resp_d_s & (cnt_d_q == 3'd0));

        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_rw_d     = mem_rw_q;
        mem_tag_d    = mem_tag_q;
        mem_valid_d  = mem_valid_q;
        if (grant_i_s) begin
            last_grant_d = SRC_I;
            mem_addr_d   = bus.i_addr_in;
            mem_data_d   = bus.i_data_in;
            mem_rw_d     = bus.i_rw_in;
            mem_tag_d    = {1'b0, bus.i_id_in};
            mem_valid_d  = 1'b1;
        end else if (grant_d_s) begin
            last_grant_d = SRC_D;
            mem_addr_d   = bus.d_addr_in;
            mem_data_d   = bus.d_data_in;
            mem_rw_d     = bus.d_rw_in;
            mem_tag_d    = {1'b1, bus.d_id_in};
            mem_valid_d  = 1'b1;
        end else if (stage_free_s) begin
            mem_valid_d  = 1'b0;
        end else begin
            mem_valid_d  = mem_valid_q;
        end

        i_ready_d = resp_i_s;
        d_ready_d = resp_d_s;
        i_data_d  = i_data_q;
        i_id_d    = i_id_q;
        d_data_d  = d_data_q;
        d_id_d    = d_id_q;
        if (resp_i_s) begin
            i_data_d = bus.mem_data_in;
            i_id_d   = bus.mem_tag_in[3:0];
        end else if (resp_d_s) begin
            d_data_d = bus.mem_data_in;
            d_id_d   = bus.mem_tag_in[3:0];
        end else begin
            i_data_d = i_data_q;
            d_data_d = d_data_q;
        end
    end

    // State and output registers; reset discards the pending request and all counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= SRC_D;
            cnt_i_q      <= 3'd0;
            cnt_d_q      <= 3'd0;
            err_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_rw_q     <= 1'b0;
            mem_tag_q    <= 5'd0;
            mem_valid_q  <= 1'b0;
            i_data_q     <= '0;
            d_data_q     <= '0;
            i_id_q       <= 4'd0;
            d_id_q       <= 4'd0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            cnt_i_q      <= cnt_i_d;
            cnt_d_q      <= cnt_d_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_rw_q     <= mem_rw_d;
            mem_tag_q    <= mem_tag_d;
            mem_valid_q  <= mem_valid_d;
            i_data_q     <= i_data_d;
            d_data_q     <= d_data_d;
            i_id_q       <= i_id_d;
            d_id_q       <= d_id_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign bus.i_stall_out   = bus.i_valid_in & ~grant_i_s;
    assign bus.d_stall_out   = bus.d_valid_in & ~grant_d_s;
    assign bus.mem_addr_out  = mem_addr_q;
    assign bus.mem_data_out  = mem_data_q;
    assign bus.mem_rw_out    = mem_rw_q;
    assign bus.mem_tag_out   = mem_tag_q;
    assign bus.mem_valid_out = mem_valid_q;
    assign bus.i_data_out    = i_data_q;
    assign bus.d_data_out    = d_data_q;
    assign bus.i_id_out      = i_id_q;
    assign bus.d_id_out      = d_id_q;
    assign bus.i_ready_out   = i_ready_q;
    assign bus.d_ready_out   = d_ready_q;
    assign bus.protocol_err  = err_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, contention, memory stall, outstanding cap,
// simultaneous grant/response and spurious responses, with hand-computed expectations.
module tb_cache_mem_arbiter;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    cache_mem_arbiter #(.DATA_WIDTH(DW), .MAX_OUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_addr_in = 32'h0; bus.d_addr_in = 32'h0;
        bus.i_data_in = 32'h0; bus.d_data_in = 32'h0;
        bus.i_rw_in = 1'b0; bus.d_rw_in = 1'b0;
        bus.i_id_in = 4'h0; bus.d_id_in = 4'h0;
        bus.i_valid_in = 1'b0; bus.d_valid_in = 1'b0;
        bus.mem_stall_in = 1'b0; bus.mem_data_in = 32'h0;
        bus.mem_tag_in = 5'h00; bus.mem_ready_in = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        bus.i_valid_in = 1'b1; bus.i_id_in = 4'h9; bus.i_addr_in = 32'h0000_1000;
        bus.d_valid_in = 1'b1; bus.d_id_in = 4'hA; bus.d_addr_in = 32'h0000_2000;
        bus.mem_ready_in = 1'b1; bus.mem_tag_in = 5'h00; bus.mem_data_in = 32'h0000_0055;
        tick();
        bus.mem_ready_in = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_valid_out !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%0h exp=0", bus.mem_valid_out); end
        checks++; if (bus.mem_tag_out !== 5'h00) begin failures++; $display("FAIL rst_mem_tag got=%0h exp=0", bus.mem_tag_out); end
        checks++; if (bus.mem_addr_out !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr_out); end
        checks++; if (bus.i_ready_out !== 1'b0) begin failures++; $display("FAIL rst_i_ready got=%0h exp=0", bus.i_ready_out); end
        checks++; if (bus.d_ready_out !== 1'b0) begin failures++; $display("FAIL rst_d_ready got=%0h exp=0", bus.d_ready_out); end
        checks++; if (bus.protocol_err !== 1'b0) begin failures++; $display("FAIL rst_protocol_err got=%0h exp=0", bus.protocol_err); end
        tick();
        checks++; if (bus.mem_valid_out !== 1'b0) begin failures++; $display("FAIL rst_hold_mem_valid got=%0h exp=0", bus.mem_valid_out); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.i_stall_out !== 1'b0) begin failures++; $display("FAIL rst_first_i_stall got=%0h exp=0", bus.i_stall_out); end
        checks++; if (bus.d_stall_out !== 1'b1) begin failures++; $display("FAIL rst_first_d_stall got=%0h exp=1", bus.d_stall_out); end
        tick();
        checks++; if (bus.mem_tag_out !== 5'h09) begin failures++; $display("FAIL rst_first_tag got=%0h exp=09", bus.mem_tag_out); end
        checks++; if (bus.mem_valid_out !== 1'b1) begin failures++; $display("FAIL rst_first_valid got=%0h exp=1", bus.mem_valid_out); end
    endtask

    task automatic test_contention;
        logic [4:0] exp_tag [4];
        exp_tag = '{5'h01, 5'h13, 5'h02, 5'h14};
        do_reset();
        bus.i_valid_in = 1'b1; bus.i_id_in = 4'h1; bus.i_addr_in = 32'h0000_0100;
        bus.d_valid_in = 1'b1; bus.d_id_in = 4'h3; bus.d_addr_in = 32'h0000_0300;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.i_stall_out !== 1'(k % 2)) begin failures++; $display("FAIL cont_i_stall cyc=%0d got=%0h exp=%0h", k, bus.i_stall_out, k % 2); end
            checks++; if (bus.d_stall_out !== 1'(1 - (k % 2))) begin failures++; $display("FAIL cont_d_stall cyc=%0d got=%0h exp=%0h", k, bus.d_stall_out, 1 - (k % 2)); end
            tick();
            checks++; if (bus.mem_tag_out !== exp_tag[k]) begin failures++; $display("FAIL cont_tag cyc=%0d got=%0h exp=%0h", k, bus.mem_tag_out, exp_tag[k]); end
            if (k == 0) bus.i_id_in = 4'h2;
            if (k == 1) bus.d_id_in = 4'h4;
        end
        idle_inputs();
    endtask

    task automatic test_mem_stall;
        do_reset();
        bus.d_valid_in = 1'b1; bus.d_id_in = 4'h5; bus.d_rw_in = 1'b1;
        bus.d_addr_in = 32'hD000_0040; bus.d_data_in = 32'h1234_5678;
        tick();
        checks++; if (bus.mem_tag_out !== 5'h15) begin failures++; $display("FAIL mstall_load_tag got=%0h exp=15", bus.mem_tag_out); end
        bus.mem_stall_in = 1'b1;
        bus.d_id_in = 4'h6; bus.d_addr_in = 32'hD000_0080; bus.d_data_in = 32'h0;
        bus.i_valid_in = 1'b1; bus.i_id_in = 4'h7; bus.i_addr_in = 32'h0000_0700;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.i_stall_out !== 1'b1) begin failures++; $display("FAIL mstall_i_stall cyc=%0d got=%0h exp=1", k, bus.i_stall_out); end
            checks++; if (bus.d_stall_out !== 1'b1) begin failures++; $display("FAIL mstall_d_stall cyc=%0d got=%0h exp=1", k, bus.d_stall_out); end
            tick();
            checks++; if (bus.mem_tag_out !== 5'h15) begin failures++; $display("FAIL mstall_hold_tag cyc=%0d got=%0h exp=15", k, bus.mem_tag_out); end
            checks++; if (bus.mem_addr_out !== 32'hD000_0040) begin failures++; $display("FAIL mstall_hold_addr cyc=%0d got=%0h exp=d0000040", k, bus.mem_addr_out); end
            checks++; if (bus.mem_data_out !== 32'h1234_5678) begin failures++; $display("FAIL mstall_hold_data cyc=%0d got=%0h exp=12345678", k, bus.mem_data_out); end
            checks++; if ({bus.mem_rw_out, bus.mem_valid_out} !== 2'b11) begin failures++; $display("FAIL mstall_hold_rw_valid cyc=%0d got=%0h exp=3", k, {bus.mem_rw_out, bus.mem_valid_out}); end
        end
        bus.mem_stall_in = 1'b0;
        #1;
        checks++; if (bus.i_stall_out !== 1'b0) begin failures++; $display("FAIL mstall_release_i_stall got=%0h exp=0", bus.i_stall_out); end
        tick();
        checks++; if (bus.mem_tag_out !== 5'h07) begin failures++; $display("FAIL mstall_release_tag got=%0h exp=07", bus.mem_tag_out); end
        idle_inputs();
    endtask

    task automatic test_outstanding_cap;
        do_reset();
        bus.i_valid_in = 1'b1; bus.i_rw_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.i_id_in = 4'(k); bus.i_addr_in = 32'(k * 16);
            #1;
            checks++; if (bus.i_stall_out !== 1'b0) begin failures++; $display("FAIL cap_fill_stall n=%0d got=%0h exp=0", k, bus.i_stall_out); end
            tick();
            checks++; if (bus.mem_tag_out !== 5'(k)) begin failures++; $display("FAIL cap_fill_tag n=%0d got=%0h exp=%0h", k, bus.mem_tag_out, k); end
        end
        bus.i_id_in = 4'h5; bus.i_addr_in = 32'h0000_0050;
        #1;
        checks++; if (bus.i_stall_out !== 1'b1) begin failures++; $display("FAIL cap_fifth_stall got=%0h exp=1", bus.i_stall_out); end
        tick();
        checks++; if (bus.mem_valid_out !== 1'b0) begin failures++; $display("FAIL cap_idle_valid got=%0h exp=0", bus.mem_valid_out); end
        bus.mem_ready_in = 1'b1; bus.mem_tag_in = 5'h02; bus.mem_data_in = 32'hCAFE_0002;
        #1;
        checks++; if (bus.i_stall_out !== 1'b0) begin failures++; $display("FAIL cap_reelig_stall got=%0h exp=0", bus.i_stall_out); end
        tick();
        checks++; if (bus.i_ready_out !== 1'b1) begin failures++; $display("FAIL cap_i_ready got=%0h exp=1", bus.i_ready_out); end
        checks++; if (bus.i_id_out !== 4'h2) begin failures++; $display("FAIL cap_i_id got=%0h exp=2", bus.i_id_out); end
        checks++; if (bus.i_data_out !== 32'hCAFE_0002) begin failures++; $display("FAIL cap_i_data got=%0h exp=cafe0002", bus.i_data_out); end
        checks++; if (bus.mem_tag_out !== 5'h05) begin failures++; $display("FAIL cap_fifth_tag got=%0h exp=05", bus.mem_tag_out); end
        bus.mem_ready_in = 1'b0; bus.i_valid_in = 1'b0;
        tick();
        checks++; if (bus.i_ready_out !== 1'b0) begin failures++; $display("FAIL cap_i_ready_pulse got=%0h exp=0", bus.i_ready_out); end
        idle_inputs();
    endtask

    task automatic test_simul_grant_resp;
        do_reset();
        bus.d_valid_in = 1'b1; bus.d_id_in = 4'h1;
        tick();
        bus.d_id_in = 4'h2;
        tick();
        bus.d_id_in = 4'h3;
        bus.mem_ready_in = 1'b1; bus.mem_tag_in = 5'h11; bus.mem_data_in = 32'hBEEF_0011;
        #1;
        checks++; if (bus.d_stall_out !== 1'b0) begin failures++; $display("FAIL simul_d_stall got=%0h exp=0", bus.d_stall_out); end
        tick();
        checks++; if (bus.d_ready_out !== 1'b1) begin failures++; $display("FAIL simul_d_ready got=%0h exp=1", bus.d_ready_out); end
        checks++; if (bus.d_id_out !== 4'h1) begin failures++; $display("FAIL simul_d_id got=%0h exp=1", bus.d_id_out); end
        checks++; if (bus.d_data_out !== 32'hBEEF_0011) begin failures++; $display("FAIL simul_d_data got=%0h exp=beef0011", bus.d_data_out); end
        checks++; if (bus.mem_tag_out !== 5'h13) begin failures++; $display("FAIL simul_tag got=%0h exp=13", bus.mem_tag_out); end
        bus.mem_ready_in = 1'b0;
        // Count must still be 2: exactly two more grants fit under the cap of 4.
        for (int k = 4; k <= 6; k++) begin
            bus.d_id_in = 4'(k);
            #1;
            checks++; if (bus.d_stall_out !== 1'(k == 6)) begin failures++; $display("FAIL simul_cap_stall id=%0d got=%0h exp=%0h", k, bus.d_stall_out, k == 6); end
            tick();
            if (k == 4) begin
                checks++; if (bus.d_ready_out !== 1'b0) begin failures++; $display("FAIL simul_d_ready_pulse got=%0h exp=0", bus.d_ready_out); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_spurious;
        do_reset();
        bus.mem_ready_in = 1'b1; bus.mem_tag_in = 5'h05; bus.mem_data_in = 32'h5A5A_0005;
        tick();
        checks++; if (bus.i_ready_out !== 1'b1) begin failures++; $display("FAIL spur_i_ready got=%0h exp=1", bus.i_ready_out); end
        checks++; if (bus.i_id_out !== 4'h5) begin failures++; $display("FAIL spur_i_id got=%0h exp=5", bus.i_id_out); end
        checks++; if (bus.i_data_out !== 32'h5A5A_0005) begin failures++; $display("FAIL spur_i_data got=%0h exp=5a5a0005", bus.i_data_out); end
        checks++; if (bus.d_ready_out !== 1'b0) begin failures++; $display("FAIL spur_d_ready got=%0h exp=0", bus.d_ready_out); end
        checks++; if (bus.protocol_err !== 1'b1) begin failures++; $display("FAIL spur_err_set got=%0h exp=1", bus.protocol_err); end
        bus.mem_ready_in = 1'b0;
        tick();
        checks++; if (bus.i_ready_out !== 1'b0) begin failures++; $display("FAIL spur_i_ready_pulse got=%0h exp=0", bus.i_ready_out); end
        repeat (3) tick();
        checks++; if (bus.protocol_err !== 1'b1) begin failures++; $display("FAIL spur_err_sticky got=%0h exp=1", bus.protocol_err); end
        do_reset();
        #1;
        checks++; if (bus.protocol_err !== 1'b0) begin failures++; $display("FAIL spur_err_cleared got=%0h exp=0", bus.protocol_err); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_contention();
        test_mem_stall();
        test_outstanding_cap();
        test_simul_grant_resp();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
